// File: rtl/execution_stage_issue.sv
// ID/EX issue register: accepts decoded instructions, forwards operands from EX/MEM,
// inserts load-use bubbles, honours flush/stall, and counts bubbles (saturating).
package execution_stage_issue_pkg;
   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src;
      logic       mem_write;
      logic       branch;
      logic       jump;
   } control_type;
endpackage

module execution_stage_issue
   import execution_stage_issue_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned REGADDR_W = 5,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 id_valid,
   output logic                 id_ready,
   input  logic [XLEN-1:0]      id_data1,
   input  logic [XLEN-1:0]      id_data2,
   input  logic [XLEN-1:0]      id_immediate,
   input  control_type          id_control,
   input  logic                 id_compflg,
   input  logic [XLEN-1:0]      id_pc,
   input  logic [REGADDR_W-1:0] id_rs1,
   input  logic [REGADDR_W-1:0] id_rs2,
   input  logic [REGADDR_W-1:0] id_rd,
   input  logic                 id_reg_write,
   input  logic                 id_mem_read,
   input  logic [XLEN-1:0]      ex_result,
   input  logic [REGADDR_W-1:0] mem_rd,
   input  logic                 mem_reg_write,
   input  logic [XLEN-1:0]      mem_result,
   input  logic                 ex_stall,
   input  logic                 flush,
   output logic [XLEN-1:0]      data1,
   output logic [XLEN-1:0]      data2,
   output logic [XLEN-1:0]      immediate_data,
   output control_type          control_out,
   output logic                 compflg_out,
   output logic [XLEN-1:0]      program_counter,
   output logic                 ex_valid,
   output logic [REGADDR_W-1:0] ex_rd,
   output logic                 ex_reg_write,
   output logic                 ex_mem_read,
   output logic [CNT_W-1:0]     bubble_count
);

   logic [XLEN-1:0]      r_data1, r_data2, r_imm, r_pc;
   control_type          r_control;
   logic                 r_compflg, r_valid, r_reg_write, r_mem_read;
   logic [REGADDR_W-1:0] r_rd;
   logic [CNT_W-1:0]     r_bubble_count;

   logic                 w_hazard;
   logic [XLEN-1:0]      w_fwd1, w_fwd2;

   // EX forwarding is only legal for non-loads; a load's data isn't ready until MEM
   function automatic logic [XLEN-1:0] fwd(input logic [REGADDR_W-1:0] rs,
                                           input logic [XLEN-1:0]      rf_val);
      logic [XLEN-1:0] v;
      v = rf_val;
      if (rs != '0) begin
         if (r_valid && r_reg_write && !r_mem_read && (r_rd == rs))
            v = ex_result;
         else if (mem_reg_write && (mem_rd == rs))
            v = mem_result;
      end
      return v;
   endfunction

   always_comb begin
      w_hazard = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
                 ((id_rs1 == r_rd) || (id_rs2 == r_rd));
      id_ready = !rst_n && !ex_stall && !w_hazard;
      w_fwd1   = fwd(id_rs1, id_data1);
      w_fwd2   = fwd(id_rs2, id_data2);
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_data1        <= '0;
         r_data2        <= '0;
         r_imm          <= '0;
         r_pc           <= '0;
         r_control      <= '0;
         r_compflg      <= 1'b0;
         r_valid        <= 1'b0;
         r_rd           <= '0;
         r_reg_write    <= 1'b0;
         r_mem_read     <= 1'b0;
         r_bubble_count <= '0;
      end else if (flush) begin
         r_valid     <= 1'b0;
         r_control   <= '0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
      end else if (ex_stall) begin
         r_valid <= r_valid;
      end else if (w_hazard) begin
         r_valid     <= 1'b0;
         r_control   <= '0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
         if (r_bubble_count != '1)
            r_bubble_count <= r_bubble_count + 1'b1;
      end else if (id_valid) begin
         r_data1     <= w_fwd1;
         r_data2     <= w_fwd2;
         r_imm       <= id_immediate;
         r_pc        <= id_pc;
         r_control   <= id_control;
         r_compflg   <= id_compflg;
         r_valid     <= 1'b1;
         r_rd        <= id_rd;
         r_reg_write <= id_reg_write;
         r_mem_read  <= id_mem_read;
      end else begin
         r_valid     <= 1'b0;
         r_control   <= '0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
      end
   end

   assign data1           = r_data1;
   assign data2           = r_data2;
   assign immediate_data  = r_imm;
   assign program_counter = r_pc;
   assign control_out     = r_control;
   assign compflg_out     = r_compflg;
   assign ex_valid        = r_valid;
   assign ex_rd           = r_rd;
   assign ex_reg_write    = r_reg_write;
   assign ex_mem_read     = r_mem_read;
   assign bubble_count    = r_bubble_count;

endmodule

// File: doc/execution_stage_issue.md
Name: execution_stage_issue

Overview:
- ID/EX issue register that drives the execute stage: data1, data2, immediate_data, control, compflg and program_counter.
- Takes decoded fields from decode with a valid/ready handshake and resolves operand forwarding from EX and MEM.
- Detects load-use hazards and inserts bubbles; handles branch flush and downstream hold.
- Keeps a saturating bubble counter for performance visibility.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- REGADDR_W, 5, register index width.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-high reset (name kept for codebase consistency).
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  issue accepts the instruction this cycle.
- id_data1, id_data2  in  XLEN  register file read values.
- id_immediate  in  XLEN  decoded immediate.
- id_control  in  control_type  decoded control (common package).
- id_compflg  in  1  compressed-instruction flag.
- id_pc  in  XLEN  instruction PC.
- id_rs1, id_rs2, id_rd  in  REGADDR_W  source and destination indices.
- id_reg_write, id_mem_read  in  1  instruction writes rd / is a load.
- ex_result  in  XLEN  combinational ALU result of the instruction currently issued.
- mem_rd  in  REGADDR_W  MEM-stage destination.
- mem_reg_write  in  1  MEM-stage write enable.
- mem_result  in  XLEN  MEM-stage writeback value.
- ex_stall  in  1  downstream hold.
- flush  in  1  branch taken; kill issued and incoming instruction.
- data1, data2, immediate_data  out  XLEN  execute operands.
- control_out  out  control_type  execute control.
- compflg_out  out  1  compressed flag.
- program_counter  out  XLEN  execute PC.
- ex_valid, ex_rd, ex_reg_write, ex_mem_read  out  1/REGADDR_W/1/1  issued-instruction status.
- bubble_count  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Reset (rst_n=1 at edge):
  - All outputs and registers go to 0: control_out all-zero (NOP), ex_valid=0, bubble_count=0.
  - id_ready reads 0 while rst_n=1.
- Latency: an instruction accepted at edge N appears on the outputs after edge N, for one cycle unless held.
- Load-use hazard, combinational:
  - hazard = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_rs1==ex_rd) | (id_rs2==ex_rd)).
  - Both sources are compared regardless of instruction format.
- id_ready = !rst_n & !ex_stall & !hazard. flush does not lower id_ready; the accepted instruction is discarded.
- Forwarding per operand, applied to the value being registered, with index rs:
  - rs==0: use id_dataX.
  - else if ex_valid & ex_reg_write & ex_rd==rs & !ex_mem_read: use ex_result.
  - else if mem_reg_write & mem_rd==rs: use mem_result.
  - else use id_dataX.
  - EX has priority over MEM.
- Edge-update priority, first match wins:
  1. rst_n: clear.
  2. flush: ex_valid=0, control_out=0, ex_reg_write=0, ex_mem_read=0; data fields don't-care. bubble_count not incremented.
  3. ex_stall: hold all outputs.
  4. hazard: insert bubble (same clearing as flush); bubble_count += 1 and saturates at all-ones.
  5. id_valid: load forwarded operands and all id fields, ex_valid=1.
  6. Otherwise: ex_valid=0, control_out=0.
- A held instruction keeps its original operands.
  - Forwarding is evaluated only on the accept edge.
  - Decode must not present a dependent instruction past a stall; id_ready=0 guarantees this.
- flush and ex_stall together: flush wins.
- A flush during an active hazard clears the load, so the hazard disappears the next cycle.
- bubble_count never wraps.

Test Plan:
- Reset, then issue add with id_pc=0x100, id_data1=5, id_data2=7, rs1=1, rs2=2, rd=3, no deps -> next cycle data1=5, data2=7, program_counter=0x100, ex_valid=1, ex_rd=3.
- Issue rd=4 (non-load), then rs1=4 while ex_result=0x2A and mem_rd=4 with mem_result=0x99 -> data1=0x2A (EX priority); repeat with rs1=0 -> data1=id_data1.
- Issue load rd=5, then rs2=5 -> id_ready=0 for 1 cycle, bubble (ex_valid=0, control_out=0), bubble_count=1; the next cycle the instruction issues, with data2=mem_result when mem_rd=5.
- Hold ex_stall=1 for 3 cycles with the pipe valid -> outputs unchanged, id_ready=0; on release the next instruction issues.
- Assert flush together with ex_stall and id_valid -> next cycle ex_valid=0, control_out=0, bubble_count unchanged.
- Force 2^CNT_W+3 hazards (use CNT_W=4 override: 19 hazards) -> bubble_count=15. Assert rst_n mid-stall -> all outputs 0 next cycle.
